// File: rtl/ps2_kb_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encodings, frame size
// and the bit layout of the memory-mapped status/data word.
package ps2_kb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rxState_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam int KB_VALID_BIT = 15;
  localparam int KB_OVF_BIT   = 14;
  localparam int KB_ERR_BIT   = 13;
  localparam int KB_ZERO_BIT  = 12;
  localparam int KB_COUNT_MSB = 11;
  localparam int KB_COUNT_LSB = 8;
  localparam int KB_BYTE_MSB  = 7;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_kb_rx_if.sv
// Memory-controller side of the keyboard receiver: pop/clear strobes in,
// status/data word and interrupt out.
interface ps2_kb_rx_if;
  logic        kb_rd_en;
  logic        kb_status_clr;
  logic [15:0] kb_data;
  logic        kb_irq;

  modport master (
    output kb_rd_en,
    output kb_status_clr,
    input  kb_data,
    input  kb_irq
  );

  modport slave (
    input  kb_rd_en,
    input  kb_status_clr,
    output kb_data,
    output kb_irq
  );
endinterface

// File: rtl/kb_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on popData.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    cnt;
  logic             doPush;
  logic             doPop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign popData = mem[rdPtr];

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 pins, deframes
// 11-bit scan-code frames and queues good bytes for the memory controller.
module ps2_kb_rx
  import ps2_kb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic          CLK_50MHZ,
  input  logic          reset,
  input  logic          PS2_CLK,
  input  logic          PS2_DATA,
  ps2_kb_rx_if.slave    kbBus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [1:0]     clkSync;
  logic [1:0]     dataSync;
  logic           clkSyncd;
  logic           dataSyncd;
  logic           filtClk;
  logic [FCW-1:0] filtCnt;
  logic           fallPulse;

  rxState_t       state;
  logic [3:0]     bitCnt;
  logic [9:0]     shiftReg;
  logic [TCW-1:0] timeoutCnt;
  logic           timeoutErr;

  logic           frameOk;
  logic           pushReq;
  logic           checkBad;
  logic           ovfSet;
  logic           errSet;
  logic           overflow;
  logic           frameErr;

  logic [7:0]     fifoHead;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [CW-1:0]  fifoCount;
  logic [4:0]     countExt;
  logic [3:0]     countField;
  logic [15:0]    kbWord;

  assign clkSyncd  = clkSync[1];
  assign dataSyncd = dataSync[1];

  // Idle-high presets keep a reset from looking like a start-of-frame edge.
  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], PS2_CLK};
      dataSync <= {dataSync[0], PS2_DATA};
    end
  end

  // A level change is accepted only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      filtClk   <= 1'b1;
      filtCnt   <= '0;
      fallPulse <= 1'b0;
    end else begin
      fallPulse <= 1'b0;
      if (clkSyncd == filtClk) begin
        filtCnt <= '0;
      end else if (filtCnt == FCW'(FILTER_LEN - 1)) begin
        filtClk   <= clkSyncd;
        filtCnt   <= '0;
        fallPulse <= filtClk;
      end else begin
        filtCnt <= filtCnt + FCW'(1);
      end
    end
  end

  // Frame deserializer: start bit arms RECV, bits 1..10 shift in LSB-first.
  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      timeoutCnt <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          timeoutCnt <= '0;
          if (fallPulse && !dataSyncd) begin
            state  <= RECV;
            bitCnt <= 4'd1;
          end
        end
        RECV: begin
          if (fallPulse) begin
            shiftReg   <= {dataSyncd, shiftReg[9:1]};
            bitCnt     <= bitCnt + 4'd1;
            timeoutCnt <= '0;
            if (bitCnt == 4'(PS2_FRAME_BITS - 1)) begin
              state <= CHECK;
            end
          end else if (timeoutCnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            state      <= IDLE;
            timeoutCnt <= '0;
            timeoutErr <= 1'b1;
          end else begin
            timeoutCnt <= timeoutCnt + TCW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign frameOk  = shiftReg[9] && oddParityOk(shiftReg[7:0], shiftReg[8]);
  assign pushReq  = (state == CHECK) && frameOk;
  assign checkBad = (state == CHECK) && !frameOk;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is not an overflow.
  assign ovfSet = pushReq && fifoFull && !kbBus.kb_rd_en;
  assign errSet = checkBad || timeoutErr;

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (ovfSet) begin
        overflow <= 1'b1;
      end else if (kbBus.kb_status_clr) begin
        overflow <= 1'b0;
      end
      if (errSet) begin
        frameErr <= 1'b1;
      end else if (kbBus.kb_status_clr) begin
        frameErr <= 1'b0;
      end
    end
  end

  kb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) fifo (
    .clk      (CLK_50MHZ),
    .rst_n    (reset),
    .push     (pushReq),
    .pushData (shiftReg[7:0]),
    .pop      (kbBus.kb_rd_en),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // The count field is four bits wide; a 16-deep full FIFO saturates it at 15.
  assign countExt   = 5'(fifoCount);
  assign countField = countExt[4] ? 4'hF : countExt[3:0];

  always_comb begin
    kbWord                             = '0;
    kbWord[KB_VALID_BIT]               = !fifoEmpty;
    kbWord[KB_OVF_BIT]                 = overflow;
    kbWord[KB_ERR_BIT]                 = frameErr;
    kbWord[KB_ZERO_BIT]                = 1'b0;
    kbWord[KB_COUNT_MSB:KB_COUNT_LSB]  = countField;
    kbWord[KB_BYTE_MSB:0]              = fifoEmpty ? 8'h00 : fifoHead;
  end

  assign kbBus.kb_data = kbWord;
  assign kbBus.kb_irq  = !fifoEmpty;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: drives PS/2 frames bit by bit and checks the
// status/data word against hand-computed values.
module tb_ps2_kb_rx;
  import ps2_kb_pkg::*;

  localparam int HALF = 20;
  localparam int TMO  = 200;

  logic clk;
  logic resetN;
  logic ps2Clk;
  logic ps2Data;
  int   testsRun;
  int   testsFailed;

  ps2_kb_rx_if kbBus ();

  ps2_kb_rx #(
    .FIFO_DEPTH     (8),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_50MHZ (clk),
    .reset     (resetN),
    .PS2_CLK   (ps2Clk),
    .PS2_DATA  (ps2Data),
    .kbBus     (kbBus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic oddPar(input logic [7:0] b);
    return ~^b;
  endfunction

  // One PS/2 bit: data set while the clock is high, then a full low phase.
  task automatic applyBit(input logic b, input bit glitch);
    ps2Data = b;
    if (glitch) begin
      repeat (5) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (4) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (HALF - 9) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic applyHead(input logic [7:0] d, input logic p, input int glitchIdx);
    applyBit(1'b0, glitchIdx == 0);
    for (int i = 0; i < 8; i++) applyBit(d[i], glitchIdx == i + 1);
    applyBit(p, glitchIdx == 9);
  endtask

  task automatic applyFrame(input logic [7:0] d, input logic p, input logic stop, input int glitchIdx);
    applyHead(d, p, glitchIdx);
    applyBit(stop, glitchIdx == 10);
    ps2Data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic popOnce();
    @(negedge clk);
    kbBus.kb_rd_en = 1'b1;
    @(negedge clk);
    kbBus.kb_rd_en = 1'b0;
  endtask

  task automatic clearFlags();
    @(negedge clk);
    kbBus.kb_status_clr = 1'b1;
    @(negedge clk);
    kbBus.kb_status_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_data got %h want %h", kbBus.kb_data, 16'h0000); end
    testsRun++;
    if (kbBus.kb_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq got %b want 0", kbBus.kb_irq); end
    testsRun++;
    if (dut.state !== IDLE) begin testsFailed++; $display("[TB] FAIL reset_state got %0d want %0d", dut.state, IDLE); end
    resetN = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    applyHead(8'h1C, 1'b0, -1);
    ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (11) @(negedge clk);
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL good_early got %h want %h", kbBus.kb_data, 16'h0000); end
    @(negedge clk);
    testsRun++;
    if (kbBus.kb_data !== 16'h811C) begin testsFailed++; $display("[TB] FAIL good_data got %h want %h", kbBus.kb_data, 16'h811C); end
    testsRun++;
    if (kbBus.kb_irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL good_irq got %b want 1", kbBus.kb_irq); end
    repeat (HALF - 12) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (30) @(negedge clk);
    popOnce();
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL good_pop got %h want %h", kbBus.kb_data, 16'h0000); end
    testsRun++;
    if (kbBus.kb_irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL good_pop_irq got %b want 0", kbBus.kb_irq); end
  endtask

  task automatic test_parity_error();
    applyFrame(8'h1C, 1'b1, 1'b1, -1);
    testsRun++;
    if (kbBus.kb_data !== 16'h2000) begin testsFailed++; $display("[TB] FAIL parity_err got %h want %h", kbBus.kb_data, 16'h2000); end
    clearFlags();
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL parity_clr got %h want %h", kbBus.kb_data, 16'h0000); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) applyFrame(8'(i), oddPar(8'(i)), 1'b1, -1);
    testsRun++;
    if (kbBus.kb_data !== 16'hC801) begin testsFailed++; $display("[TB] FAIL ovf_full got %h want %h", kbBus.kb_data, 16'hC801); end
    for (int i = 1; i <= 8; i++) begin
      testsRun++;
      if (kbBus.kb_data[7:0] !== 8'(i)) begin testsFailed++; $display("[TB] FAIL ovf_order got %h want %h", kbBus.kb_data[7:0], 8'(i)); end
      popOnce();
    end
    testsRun++;
    if (kbBus.kb_data !== 16'h4000) begin testsFailed++; $display("[TB] FAIL ovf_drained got %h want %h", kbBus.kb_data, 16'h4000); end
    clearFlags();
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL ovf_clr got %h want %h", kbBus.kb_data, 16'h0000); end
  endtask

  task automatic test_timeout();
    applyBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyBit(i[0], 1'b0);
    ps2Data = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    testsRun++;
    if (kbBus.kb_data !== 16'h2000) begin testsFailed++; $display("[TB] FAIL timeout_err got %h want %h", kbBus.kb_data, 16'h2000); end
    testsRun++;
    if (dut.state !== IDLE) begin testsFailed++; $display("[TB] FAIL timeout_state got %0d want %0d", dut.state, IDLE); end
    applyFrame(8'h5A, oddPar(8'h5A), 1'b1, -1);
    testsRun++;
    if (kbBus.kb_data !== 16'hA15A) begin testsFailed++; $display("[TB] FAIL timeout_next got %h want %h", kbBus.kb_data, 16'hA15A); end
    clearFlags();
    popOnce();
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL timeout_clean got %h want %h", kbBus.kb_data, 16'h0000); end
  endtask

  task automatic test_push_pop_glitch();
    applyFrame(8'h11, oddPar(8'h11), 1'b1, -1);
    testsRun++;
    if (kbBus.kb_data !== 16'h8111) begin testsFailed++; $display("[TB] FAIL pp_first got %h want %h", kbBus.kb_data, 16'h8111); end
    applyHead(8'h22, oddPar(8'h22), -1);
    ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (11) @(negedge clk);
    kbBus.kb_rd_en = 1'b1;
    @(negedge clk);
    kbBus.kb_rd_en = 1'b0;
    testsRun++;
    if (kbBus.kb_data !== 16'h8122) begin testsFailed++; $display("[TB] FAIL pp_same got %h want %h", kbBus.kb_data, 16'h8122); end
    repeat (HALF - 12) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (30) @(negedge clk);
    applyFrame(8'h33, oddPar(8'h33), 1'b1, 4);
    testsRun++;
    if (kbBus.kb_data !== 16'h8222) begin testsFailed++; $display("[TB] FAIL glitch_data got %h want %h", kbBus.kb_data, 16'h8222); end
    popOnce();
    testsRun++;
    if (kbBus.kb_data !== 16'h8133) begin testsFailed++; $display("[TB] FAIL glitch_head got %h want %h", kbBus.kb_data, 16'h8133); end
    popOnce();
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL glitch_empty got %h want %h", kbBus.kb_data, 16'h0000); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 1; i <= 3; i++) applyFrame(8'(i), oddPar(8'(i)), 1'b1, -1);
    testsRun++;
    if (kbBus.kb_data !== 16'h8301) begin testsFailed++; $display("[TB] FAIL mid_queued got %h want %h", kbBus.kb_data, 16'h8301); end
    applyBit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyBit(~i[0], 1'b0);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    testsRun++;
    if (kbBus.kb_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL mid_async got %h want %h", kbBus.kb_data, 16'h0000); end
    testsRun++;
    if (dut.state !== IDLE) begin testsFailed++; $display("[TB] FAIL mid_state got %0d want %0d", dut.state, IDLE); end
    ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    applyFrame(8'h1C, oddPar(8'h1C), 1'b1, -1);
    testsRun++;
    if (kbBus.kb_data !== 16'h811C) begin testsFailed++; $display("[TB] FAIL mid_after got %h want %h", kbBus.kb_data, 16'h811C); end
  endtask

  initial begin
    testsRun            = 0;
    testsFailed         = 0;
    resetN              = 1'b0;
    ps2Clk              = 1'b1;
    ps2Data             = 1'b1;
    kbBus.kb_rd_en      = 1'b0;
    kbBus.kb_status_clr = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_push_pop_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ps2_kb_rx.md
Name: ps2_kb_rx

Overview:
- PS/2 keyboard receiver feeding the CPU's memory-mapped input path: upstream of the memory controller, alongside the LCD register on the output side.
- Samples the board PS/2 pins, filters the PS/2 clock, and deframes 11-bit scan-code frames.
- Checks start, stop and odd parity, then buffers good bytes in a small FIFO.
- Presents a 16-bit status/data word that the memory controller returns on reads of the keyboard address, and accepts a pop strobe.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, 2..16.
- FILTER_LEN, 8, consecutive equal PS2_CLK samples needed to accept a level change.
- TIMEOUT_CYCLES, 10000, idle clocks mid-frame before the frame is abandoned (200 us at 50 MHz).

Ports:
- CLK_50MHZ  in  1  system clock.
- reset  in  1  asynchronous, active-low; low clears all state.
- PS2_CLK  in  1  raw PS/2 clock pin (asynchronous).
- PS2_DATA  in  1  raw PS/2 data pin (asynchronous).
- kb_rd_en  in  1  one-cycle pop strobe from the memory controller.
- kb_status_clr  in  1  one-cycle strobe; clears the sticky overflow and error flags.
- kb_data  out  16  [15] valid (FIFO non-empty), [14] overflow sticky, [13] frame_err sticky, [12] 0, [11:8] count, [7:0] head byte (0x00 when empty).
- kb_irq  out  1  equals valid.

Behaviour:
- Reset (async, active-low):
  - FIFO empty, count 0, sticky flags 0, FSM in IDLE.
  - kb_data = 16'h0000, kb_irq = 0.
  - Filtered clock = 1; both synchronizers preset to 1.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-flop synchronizer.
  - The filtered clock changes only after FILTER_LEN identical consecutive synchronized samples.
  - A falling edge is a 1-to-0 transition of the filtered clock, producing a one-cycle fall pulse.
  - Data is sampled from the synchronized PS2_DATA in the fall-pulse cycle.
- FSM:
  - IDLE: on a fall pulse with data = 0 (start bit), go to RECV with bit_cnt = 1. A fall pulse with data = 1 is ignored.
  - RECV: each fall pulse shifts data in LSB-first (bits 1..8 are data, 9 is parity, 10 is stop) and increments bit_cnt. On the pulse that captures bit 10, go to CHECK.
  - CHECK (one cycle): the frame is good if the stop bit = 1 and XOR(data[7:0], parity) = 1 (odd parity). Good frame: push. Bad frame: set frame_err, no push. Always return to IDLE.
  - Timeout: a counter resets on every fall pulse while in RECV. When it reaches TIMEOUT_CYCLES, discard the partial frame, set frame_err, and return to IDLE.
- FIFO, show-ahead:
  - kb_data[7:0] is the head entry, combinational from the FIFO registers.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH in a 4-bit field.
  - Push when full: the byte is dropped and overflow is set; FIFO contents are unchanged.
  - kb_rd_en when empty: ignored; no flag change.
  - Push and pop in the same cycle: both occur and count is unchanged. If empty, the push occurs and the pop is ignored. If full, pop and push both succeed with no overflow.
- Sticky flags:
  - kb_status_clr clears overflow and frame_err.
  - If a set event and kb_status_clr coincide, the set wins (flag = 1 after the edge).
- Latency:
  - A good byte is visible on kb_data the cycle after CHECK, i.e. 2 clocks after the fall pulse for the stop bit.
  - That fall pulse itself lags the raw pin edge by 2 (sync) + FILTER_LEN clocks.
  - After a pop, the new head and count are visible on the next clock.
- All outputs are registered state or combinational reads of registered state; there is no combinational path from kb_rd_en to kb_data.

Decomposition:
- Shared package ps2_kb_pkg:
  - FSM state encodings (IDLE, RECV, CHECK).
  - PS2_FRAME_BITS = 11.
  - kb_data bit positions (KB_VALID_BIT = 15, KB_OVF_BIT = 14, KB_ERR_BIT = 13, count [11:8], byte [7:0]).
- One sub-module, kb_fifo: a synchronous show-ahead FIFO parameterized by depth and 8-bit width, exposing full, empty and count. Synchronizers, filter, FSM and flags stay in the top level.

Test Plan:
- Good frame, scan code 0x1C (parity 0, stop 1), at a 12.5 kHz PS/2 clock -> kb_data = 16'h811C, kb_irq = 1. After a kb_rd_en pulse -> kb_data = 16'h0000 next clock.
- Frame 0x1C sent with parity 1 -> no push; kb_data = 16'h2000. Then kb_status_clr -> 16'h0000.
- Nine good frames 0x01..0x09 with no reads -> count 8, overflow set, kb_data = 16'hC801. Eight pops return 0x01..0x08 in order; 0x09 is lost.
- Start bit plus 4 data bits, then the clock idles for TIMEOUT_CYCLES + 10 -> frame_err set, FSM IDLE. A following good frame 0x5A -> kb_data = 16'hA15A.
- FIFO holding 0x11: kb_rd_en asserted in the same cycle as the push of 0x22 -> count stays 1, head becomes 0x22. A glitch on PS2_CLK shorter than FILTER_LEN clocks mid-frame -> no extra bit is captured.
- reset pulled low mid-frame (after bit 5) with 3 bytes queued -> kb_data = 16'h0000 immediately (asynchronous). After release, a new good frame 0x1C -> 16'h811C.
